// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM bus controller.
// SRAM_CTRL_RMW_EN adds the read-modify-write states for single-byte halfword writes.
package sram_ctrl_pkg;

  localparam int unsigned CNT_W        = 4;
  localparam int unsigned WAIT_CYC_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
`ifdef SRAM_CTRL_RMW_EN
    ST_RMW_LO,
    ST_RMW_HI,
`endif
    ST_RESP
  } state_e;

  // First state needed once the low halfword is finished (or skipped).
  function automatic state_e hi_entry(logic wen, logic [3:0] strb);
    hi_entry = ST_RESP;
    if (!wen || (strb[3:2] != 2'b00)) hi_entry = ST_HI;
`ifdef SRAM_CTRL_RMW_EN
    if (wen && (strb[3] ^ strb[2])) hi_entry = ST_RMW_HI;
`endif
  endfunction

  function automatic state_e lo_entry(logic wen, logic [3:0] strb);
    lo_entry = hi_entry(wen, strb);
    if (!wen || (strb[1:0] != 2'b00)) lo_entry = ST_LO;
`ifdef SRAM_CTRL_RMW_EN
    if (wen && (strb[1] ^ strb[0])) lo_entry = ST_RMW_LO;
`endif
  endfunction

  function automatic logic [15:0] merge_half(logic [15:0] wdat, logic [1:0] strb,
                                             logic [15:0] rdat);
    merge_half = {strb[1] ? wdat[15:8] : rdat[15:8], strb[0] ? wdat[7:0] : rdat[7:0]};
  endfunction

endpackage

// File: rtl/sram_bus_ctrl_if.sv
// Core request/response channel plus SRAM pin-driver signals of the bus controller.
interface sram_bus_ctrl_if #(
  parameter int unsigned AW = 22,
  parameter int unsigned DW = 16
);
  logic          req_valid;
  logic          req_ready;
  logic          req_wen;
  logic [AW:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] mem_address;
  logic          mem_wren;
  logic          mem_rden;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready, data_out,
    output req_ready, rsp_valid, rsp_rdata, mem_address, mem_wren, mem_rden, data_in
  );

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready, data_out,
    input  req_ready, rsp_valid, rsp_rdata, mem_address, mem_wren, mem_rden, data_in
  );
endinterface

// File: rtl/sram_wait_timer.sv
// Per-access timer: WAIT_CYC strobe cycles then one turnaround cycle.
module sram_wait_timer
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  output logic last,
  output logic done
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WAIT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             turn_q, turn_d;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    turn_d   = turn_q;
    if (load) begin
      cnt_d    = RELOAD;
      active_d = 1'b1;
      turn_d   = 1'b0;
    end else if (active_q) begin
      if (turn_q) begin
        active_d = 1'b0;
        turn_d   = 1'b0;
      end else if (cnt_q == '0) begin
        turn_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      turn_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      turn_q   <= turn_d;
    end
  end

  assign last = active_q && !turn_q && (cnt_q == '0);
  assign done = active_q && turn_q;

endmodule

// File: rtl/sram_bus_ctrl.sv
// 32-bit request to two 16-bit SRAM accesses, all outputs registered.
// Define SRAM_CTRL_RMW_EN for read-modify-write of single-byte-strobed halfwords.
module sram_bus_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned AW       = 22,
  parameter int unsigned DW       = 16,
  parameter int unsigned WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic           CLK,
  input  logic           RST,
  sram_bus_ctrl_if.slave bus
);

  state_e        state_q, state_d, nxt;
  logic          wen_q, wen_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW-2:0] word_q, word_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wren_q, wren_d;
  logic          rden_q, rden_d;
  logic [15:0]   din_q, din_d;
  logic [15:0]   lo_wr, hi_wr;
  logic          enter, load, last, done;
  logic          unused_addr_bits;
`ifdef SRAM_CTRL_RMW_EN
  logic [15:0]   rmw_q, rmw_d;
`endif

  assign unused_addr_bits = ^bus.req_addr[1:0];

  sram_wait_timer #(.WAIT_CYC(WAIT_CYC)) u_timer (
    .CLK  (CLK),
    .RST  (RST),
    .load (load),
    .last (last),
    .done (done)
  );

`ifdef SRAM_CTRL_RMW_EN
  assign lo_wr = merge_half(wdata_d[15:0],  wstrb_d[1:0], rmw_q);
  assign hi_wr = merge_half(wdata_d[31:16], wstrb_d[3:2], rmw_q);
`else
  assign lo_wr = wdata_d[15:0];
  assign hi_wr = wdata_d[31:16];
`endif

  always_comb begin
    wen_d       = wen_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    addr_d      = addr_q;
    wren_d      = wren_q;
    rden_d      = rden_q;
    din_d       = din_q;
`ifdef SRAM_CTRL_RMW_EN
    rmw_d       = rmw_q;
`endif
    nxt         = state_q;
    enter       = 1'b0;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          wen_d       = bus.req_wen;
          wstrb_d     = bus.req_wstrb;
          wdata_d     = bus.req_wdata;
          word_d      = bus.req_addr[AW:2];
          rsp_rdata_d = '0;
          nxt         = lo_entry(bus.req_wen, bus.req_wstrb);
          enter       = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          nxt         = ST_IDLE;
        end
      end
      default: begin
        if (last) begin
          rden_d = 1'b0;
          wren_d = 1'b0;
          if (state_q == ST_LO && !wen_q) rsp_rdata_d[15:0]  = bus.data_out;
          if (state_q == ST_HI && !wen_q) rsp_rdata_d[31:16] = bus.data_out;
`ifdef SRAM_CTRL_RMW_EN
          if (state_q == ST_RMW_LO || state_q == ST_RMW_HI) rmw_d = bus.data_out;
`endif
        end
        if (done) begin
          enter = 1'b1;
          case (state_q)
            ST_LO:     nxt = hi_entry(wen_q, wstrb_q);
`ifdef SRAM_CTRL_RMW_EN
            ST_RMW_LO: nxt = ST_LO;
            ST_RMW_HI: nxt = ST_HI;
`endif
            default:   nxt = ST_RESP;
          endcase
        end
      end
    endcase

    // Strobes, address and data for the next access are registered on the entry edge.
    if (enter) begin
      case (nxt)
        ST_LO: begin
          addr_d = {word_d, 1'b0};
          rden_d = !wen_d;
          wren_d = wen_d;
          din_d  = wen_d ? lo_wr : '0;
          load   = 1'b1;
        end
        ST_HI: begin
          addr_d = {word_d, 1'b1};
          rden_d = !wen_d;
          wren_d = wen_d;
          din_d  = wen_d ? hi_wr : '0;
          load   = 1'b1;
        end
`ifdef SRAM_CTRL_RMW_EN
        ST_RMW_LO: begin
          addr_d = {word_d, 1'b0};
          rden_d = 1'b1;
          din_d  = '0;
          load   = 1'b1;
        end
        ST_RMW_HI: begin
          addr_d = {word_d, 1'b1};
          rden_d = 1'b1;
          din_d  = '0;
          load   = 1'b1;
        end
`endif
        ST_RESP: rsp_valid_d = 1'b1;
        default: ;
      endcase
    end

    state_d     = nxt;
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      wen_q       <= 1'b0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      word_q      <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      wren_q      <= 1'b0;
      rden_q      <= 1'b0;
      din_q       <= '0;
`ifdef SRAM_CTRL_RMW_EN
      rmw_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wen_q       <= wen_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      word_q      <= word_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      addr_q      <= addr_d;
      wren_q      <= wren_d;
      rden_q      <= rden_d;
      din_q       <= din_d;
`ifdef SRAM_CTRL_RMW_EN
      rmw_q       <= rmw_d;
`endif
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wren    = wren_q;
  assign bus.mem_rden    = rden_q;
  assign bus.data_in     = din_q;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Bench for sram_bus_ctrl: per-request access list model plus directed literal checks.
`timescale 1ns/1ps
module tb_sram_bus_ctrl;

  localparam int unsigned AW   = 22;
  localparam int unsigned WC   = 2;
  localparam int unsigned SLOT = WC + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_bus_ctrl_if #(.AW(AW), .DW(16)) bus ();

  sram_bus_ctrl #(.AW(AW), .DW(16), .WAIT_CYC(WC)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] pin_mem [int unsigned];
  logic [15:0] ref_mem [int unsigned];

  function automatic logic [15:0] dflt(int unsigned a);
    dflt = 16'((a * 32'h9E37) ^ 32'h5A5A);
  endfunction

  function automatic logic [15:0] pin_rd(int unsigned a);
    pin_rd = pin_mem.exists(a) ? pin_mem[a] : dflt(a);
  endfunction

  function automatic logic [15:0] ref_rd(int unsigned a);
    ref_rd = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Pin driver stand-in: commits writes, presents read data for the current address.
  always @(negedge clk) begin
    if (bus.mem_wren) pin_mem[32'(bus.mem_address)] = bus.data_in;
    bus.data_out = pin_rd(32'(bus.mem_address));
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    bit          rd;
    int unsigned a;
    logic [15:0] d;
  } acc_t;

  acc_t        accs[$];
  logic [31:0] exp_rsp;

  // Expected SRAM accesses for one request, in order; also updates the reference memory.
  task automatic build(input bit wen, input logic [AW:0] addr, input logic [31:0] wd,
                       input logic [3:0] st);
    int unsigned lo;
    int unsigned a;
    logic [1:0]  s;
    logic [15:0] d, old, nv;
    acc_t        e;
    accs.delete();
    exp_rsp = '0;
    lo = 32'(addr[AW:2]) * 2;
    if (!wen) begin
      e.rd = 1'b1; e.d = '0;
      e.a = lo;     accs.push_back(e);
      e.a = lo + 1; accs.push_back(e);
      exp_rsp = {ref_rd(lo + 1), ref_rd(lo)};
    end else begin
      for (int h = 0; h < 2; h++) begin
        s   = st[2*h +: 2];
        d   = wd[16*h +: 16];
        a   = lo + 32'(h);
        old = ref_rd(a);
        if (s == 2'b00) continue;
        nv = d;
`ifdef SRAM_CTRL_RMW_EN
        if (s != 2'b11) begin
          e.rd = 1'b1; e.a = a; e.d = '0;
          accs.push_back(e);
          nv = {s[1] ? d[15:8] : old[15:8], s[0] ? d[7:0] : old[7:0]};
        end
`endif
        e.rd = 1'b0; e.a = a; e.d = nv;
        accs.push_back(e);
        ref_mem[a] = nv;
      end
    end
  endtask

  task automatic xact(input bit wen, input logic [AW:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input int unsigned hold,
                      output logic [31:0] got, output int first_rsp);
    int unsigned tot, idx, off, to;
    bit          er, ew;
    build(wen, addr, wd, st);
    tot = accs.size() * SLOT;
    to  = 0;
    while (bus.req_ready !== 1'b1 && to < 20) begin
      @(negedge clk);
      to++;
    end
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_wen   = wen;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_wstrb = st;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    bus.req_wstrb = 4'($urandom);
    first_rsp = -1;
    for (int unsigned c = 1; c <= tot; c++) begin
      idx = (c - 1) / SLOT;
      off = (c - 1) % SLOT;
      er  = (off < WC) && accs[idx].rd;
      ew  = (off < WC) && !accs[idx].rd;
      chk("mem_rden", 32'(bus.mem_rden), 32'(er));
      chk("mem_wren", 32'(bus.mem_wren), 32'(ew));
      if (er || ew) chk("mem_address", 32'(bus.mem_address), accs[idx].a);
      if (ew) chk("data_in", 32'(bus.data_in), 32'(accs[idx].d));
      chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
      if (bus.rsp_valid && first_rsp < 0) first_rsp = int'(c);
      chk("rsp_valid_early", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end
    if (bus.rsp_valid && first_rsp < 0) first_rsp = int'(tot + 1);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_rdata", bus.rsp_rdata, exp_rsp);
    got = bus.rsp_rdata;
    for (int unsigned k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("rsp_valid_hold", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_rdata_hold", bus.rsp_rdata, exp_rsp);
      chk("req_ready_hold", 32'(bus.req_ready), 32'd0);
      chk("strobes_hold", 32'({bus.mem_wren, bus.mem_rden}), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    chk("req_ready_after", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    int          fr;
    logic [20:0] word;
    bus.req_valid = 1'b0;
    bus.req_wen   = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    bus.rsp_ready = 1'b0;
    bus.data_out  = '0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_strobes", 32'({bus.mem_wren, bus.mem_rden}), 32'd0);
    chk("rst_mem_address", 32'(bus.mem_address), 32'd0);
    chk("rst_data_in", 32'(bus.data_in), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_post_rst", 32'(bus.req_ready), 32'd1);

    // Read of word 0x10: halfwords 8 and 9.
    pin_mem[8] = 16'h1234; ref_mem[8] = 16'h1234;
    pin_mem[9] = 16'hABCD; ref_mem[9] = 16'hABCD;
    xact(1'b0, 23'h10, 32'h0, 4'h0, 0, got, fr);
    chk("tp_read_rdata", got, 32'hABCD1234);
    chk("tp_read_rsp_cycle", 32'(fr), 32'd7);

    xact(1'b1, 23'h20, 32'hDEADBEEF, 4'hF, 1, got, fr);
    chk("tp_write_rdata", got, 32'd0);
    chk("tp_write_lo", 32'(pin_rd(16)), 32'h0000BEEF);
    chk("tp_write_hi", 32'(pin_rd(17)), 32'h0000DEAD);
    chk("tp_write_rsp_cycle", 32'(fr), 32'd7);

    xact(1'b1, 23'h40, 32'h11223344, 4'hC, 0, got, fr);
    chk("tp_hi_only_rsp_cycle", 32'(fr), 32'(WC + 2));
    chk("tp_hi_only_lo_kept", 32'(pin_rd(32)), 32'(dflt(32)));
    chk("tp_hi_only_hi", 32'(pin_rd(33)), 32'h00001122);

    xact(1'b1, 23'h50, 32'h99999999, 4'h0, 0, got, fr);
    chk("tp_no_strobe_rsp_cycle", 32'(fr), 32'd1);
    chk("tp_no_strobe_mem", 32'(pin_rd(40)), 32'(dflt(40)));

    pin_mem[48] = 16'h5566; ref_mem[48] = 16'h5566;
    xact(1'b1, 23'h60, 32'h000000AA, 4'h1, 0, got, fr);
`ifdef SRAM_CTRL_RMW_EN
    chk("tp_partial_rmw", 32'(pin_rd(48)), 32'h000055AA);
    chk("tp_partial_rsp_cycle", 32'(fr), 32'(2 * SLOT + 1));
`else
    chk("tp_partial_full", 32'(pin_rd(48)), 32'h000000AA);
    chk("tp_partial_rsp_cycle", 32'(fr), 32'(SLOT + 1));
`endif

    xact(1'b0, 23'h20, 32'h0, 4'h0, 5, got, fr);
    chk("tp_hold_rdata", got, 32'hDEADBEEF);

    // Reset during the high-halfword strobe of a read.
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b0;
    bus.req_addr  = 23'h10;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (WC + 1) @(negedge clk);
    chk("rst_mid_hi_rden", 32'(bus.mem_rden), 32'd1);
    chk("rst_mid_hi_addr", 32'(bus.mem_address), 32'd9);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_strobes", 32'({bus.mem_wren, bus.mem_rden}), 32'd0);
    chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready_after", 32'(bus.req_ready), 32'd1);
    repeat (2 * SLOT + 2) begin
      @(negedge clk);
      chk("rst_mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("rst_mid_quiet", 32'({bus.mem_wren, bus.mem_rden}), 32'd0);
    end

    for (int i = 0; i < 60; i++) begin
      word = ($urandom_range(0, 3) == 0) ? 21'h1FFFF0 + 21'($urandom_range(0, 15))
                                         : 21'($urandom_range(0, 15));
      xact(1'($urandom_range(0, 1)), {word, 2'($urandom)}, $urandom, 4'($urandom),
           $urandom_range(0, 3), got, fr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
